retry_remote_responder: RTL
===========================

# retry_remote_responder

Remote Retry State Machine (RRSM) for the link-layer retry path. It accepts a CRC-clean RETRY.Req from the unpacker and requests a RETRY.Ack from the control-flit packer. Once the Ack has been sent, it replays the Link Layer Retry Buffer (LLRB) from the requested Eseq up to the current write pointer. It sits beside the local retry block, between the unpacker, the controller and the LLRB read port.

## Interface
Parameters:
- LLRB_DEPTH, 256: number of LLRB entries; must be a power of 2.
- PTR_W, $clog2(LLRB_DEPTH): width of LLRB pointers and Eseq.

Ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  asynchronous, active-low reset
- unpacker_valid_sig  in  1  received flit valid this cycle
- unpacker_valid_crc  in  1  received flit passed CRC
- unpacker_req_seq_flag  in  1  received flit is RETRY.Req
- unpacker_rdptr_eseq_num  in  PTR_W  Eseq field of the RETRY.Req
- unpacker_retryreq_num  in  5  NUM_RETRY field of the RETRY.Req
- retry_wrt_ptr  in  PTR_W  LLRB write pointer (next free entry)
- llrb_oldest_ptr  in  PTR_W  oldest un-acked LLRB entry
- controller_ack_sent_flag  in  1  RETRY.Ack left the packer this cycle
- controller_rd_en  in  1  one replay flit consumed from LLRB this cycle
- retry_send_ack_seq  out  1  request to send RETRY.Ack
- rrsm_ack_eseq  out  PTR_W  Eseq to echo in the Ack
- rrsm_ack_num_retry  out  5  NUM_RETRY to echo in the Ack
- rrsm_ack_empty_bit  out  1  Ack Empty bit; nothing to replay
- rrsm_replay_active  out  1  replay in progress; the transmitter must stall new flits
- rrsm_replay_rd_ptr  out  PTR_W  LLRB read address for replay
- rrsm_replay_last  out  1  current rd_ptr is the final replay entry
- rrsm_state  out  2  current RRSM state (debug)
- rrsm_bad_req_cnt  out  8  saturating count of dropped out-of-window requests

## Operation
- Accepted request: unpacker_valid_sig & unpacker_valid_crc & unpacker_req_seq_flag, and (when checking is compiled in) the Eseq is in window.
- Window rule: all arithmetic is mod LLRB_DEPTH.
  - In window iff (eseq − oldest) ≤ (wrt − oldest).
  - eseq == wrt is legal and means empty.
- On acceptance, register:
  - Eseq, num_retry.
  - end_ptr = retry_wrt_ptr (snapshot).
  - empty = (eseq == retry_wrt_ptr).
- States (rrsm_state encoding):
  - IDLE = 0: waits for an accepted request, then goes to ACK_PEND.
  - ACK_PEND = 1: retry_send_ack_seq = 1; the rrsm_ack_* outputs hold the captured values. On controller_ack_sent_flag: if empty → IDLE, else → REPLAY with rd_ptr = eseq.
  - REPLAY = 2: rrsm_replay_active = 1. Each controller_rd_en sets rd_ptr = (rd_ptr + 1) mod LLRB_DEPTH. rrsm_replay_last = ((rd_ptr + 1) mod LLRB_DEPTH == end_ptr). controller_rd_en while last → IDLE.
- New accepted request while in ACK_PEND: the captured fields are overwritten; stay in ACK_PEND.
- New accepted request while in REPLAY: abort the replay, capture the new fields, go to ACK_PEND.
- Simultaneous events: an accepted request takes priority over controller_ack_sent_flag and over controller_rd_en in the same cycle.
- Ignored inputs:
  - controller_ack_sent_flag outside ACK_PEND.
  - controller_rd_en outside REPLAY.
  - Requests with bad CRC (never counted).
- Out-of-window request with valid CRC: dropped, no state change; rrsm_bad_req_cnt increments and saturates at 255.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state resets to IDLE, including on assertion mid-replay.
- Request accepted in cycle N → retry_send_ack_seq and the rrsm_ack_* outputs are valid in N+1.
- controller_ack_sent_flag in cycle M:
  - REPLAY with rrsm_replay_active = 1 and rd_ptr = eseq in M+1, or
  - IDLE in M+1 if empty.
- controller_rd_en in cycle K → updated rd_ptr and rrsm_replay_last in K+1. The LLRB read is combinational on rrsm_replay_rd_ptr.
- controller_rd_en in a cycle with rrsm_replay_last = 1 → rrsm_replay_active = 0 in the next cycle.
- Pointers wrap: rd_ptr = LLRB_DEPTH−1 followed by rd_en gives rd_ptr = 0.

## Configuration
- RRSM_ESEQ_CHECK_EN defined: the window check is active and rrsm_bad_req_cnt counts as described above.
- RRSM_ESEQ_CHECK_EN undefined:
  - Every CRC-valid RETRY.Req is accepted.
  - llrb_oldest_ptr is unused.
  - rrsm_bad_req_cnt is tied to 0.

## Structure
- Shared package retry_pkg:
  - rrsm_state_e enum (IDLE, ACK_PEND, REPLAY).
  - Default LLRB_DEPTH and the PTR_W derivation.
  - Saturating-counter width constant.
- Sub-module rrsm_eseq_window_chk: combinational modular window compare producing in_window and empty. It is instantiated only under RRSM_ESEQ_CHECK_EN.

## Test plan
- Normal replay: wrt = 10, oldest = 4, Req eseq = 7 → Ack requested with eseq 7 next cycle; after ack_sent, rd_ptr goes 7, 8, 9; last is set at 9; IDLE after the 3rd rd_en.
- Empty request: eseq = 10 == wrt → Ack with empty_bit = 1; after ack_sent, return to IDLE with no replay.
- Wrap-around: DEPTH = 256, oldest = 250, wrt = 3, eseq = 254 → replay 254, 255, 0, 1, 2; last at 2.
- Out-of-window request: oldest = 4, wrt = 10, eseq = 20 → no Ack, state unchanged, rrsm_bad_req_cnt = 1. With the macro undefined → accepted.
- Preemption: during REPLAY at rd_ptr = 8, a new Req with eseq = 5 arrives together with rd_en → ACK_PEND with eseq 5 and rd_en ignored.
- Reset mid-REPLAY: i_rst_n low → all outputs 0 and state IDLE asynchronously; a fresh Req after release behaves normally.

Source files
------------

// File: rtl/retry_pkg.sv
// Shared types and constants for the remote retry state machine (RRSM).
// Used by retry_remote_responder and rrsm_eseq_window_chk.
package retry_pkg;

    localparam int LLRB_DEPTH_DEF = 256;
    localparam int PTR_W_DEF      = $clog2(LLRB_DEPTH_DEF);
    localparam int BAD_CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK_PEND = 2'd1,
        REPLAY   = 2'd2
    } rrsm_state_e;

endpackage

// File: rtl/rrsm_eseq_window_chk.sv
// Modular Eseq window compare against the live LLRB span [oldest, wrt].
// Pointer subtraction wraps naturally because the LLRB depth is a power of two.
module rrsm_eseq_window_chk #(
    parameter int PTR_W = 8
) (
    input  logic [PTR_W-1:0] eseq,
    input  logic [PTR_W-1:0] wrt_ptr,
    input  logic [PTR_W-1:0] oldest_ptr,
    output logic             in_window,
    output logic             empty
);

    logic [PTR_W-1:0] eseq_off;
    logic [PTR_W-1:0] span;

    assign eseq_off  = eseq - oldest_ptr;
    assign span      = wrt_ptr - oldest_ptr;
    assign in_window = (eseq_off <= span);
    assign empty     = (eseq == wrt_ptr);

endmodule

// File: rtl/retry_remote_responder.sv
// Remote retry state machine: accepts RETRY.Req, requests RETRY.Ack, then replays the LLRB.
// Optional Eseq window checking is compiled in with RRSM_ESEQ_CHECK_EN.
module retry_remote_responder
    import retry_pkg::*;
#(
    parameter int LLRB_DEPTH = LLRB_DEPTH_DEF,
    parameter int PTR_W      = $clog2(LLRB_DEPTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 unpacker_valid_sig,
    input  logic                 unpacker_valid_crc,
    input  logic                 unpacker_req_seq_flag,
    input  logic [PTR_W-1:0]     unpacker_rdptr_eseq_num,
    input  logic [4:0]           unpacker_retryreq_num,
    input  logic [PTR_W-1:0]     retry_wrt_ptr,
    input  logic [PTR_W-1:0]     llrb_oldest_ptr,
    input  logic                 controller_ack_sent_flag,
    input  logic                 controller_rd_en,
    output logic                 retry_send_ack_seq,
    output logic [PTR_W-1:0]     rrsm_ack_eseq,
    output logic [4:0]           rrsm_ack_num_retry,
    output logic                 rrsm_ack_empty_bit,
    output logic                 rrsm_replay_active,
    output logic [PTR_W-1:0]     rrsm_replay_rd_ptr,
    output logic                 rrsm_replay_last,
    output logic [1:0]           rrsm_state,
    output logic [BAD_CNT_W-1:0] rrsm_bad_req_cnt
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    rrsm_state_e      state_q, state_d;
    logic [PTR_W-1:0] eseq_q, eseq_d;
    logic [4:0]       num_q, num_d;
    logic [PTR_W-1:0] end_q, end_d;
    logic             empty_q, empty_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             ack_q, ack_d;
    logic             active_q, active_d;
    logic             last_q, last_d;

    logic req_hit;
    logic in_window;
    logic empty_new;
    logic accept;

    assign req_hit = unpacker_valid_sig & unpacker_valid_crc & unpacker_req_seq_flag;

`ifdef RRSM_ESEQ_CHECK_EN
    rrsm_eseq_window_chk #(
        .PTR_W(PTR_W)
    ) u_window_chk (
        .eseq      (unpacker_rdptr_eseq_num),
        .wrt_ptr   (retry_wrt_ptr),
        .oldest_ptr(llrb_oldest_ptr),
        .in_window (in_window),
        .empty     (empty_new)
    );

    logic [BAD_CNT_W-1:0] bad_cnt_q;

    function automatic logic [BAD_CNT_W-1:0] sat_inc(input logic [BAD_CNT_W-1:0] v);
        return (v == {BAD_CNT_W{1'b1}}) ? v : v + BAD_CNT_W'(1);
    endfunction

    // Only CRC-clean requests that fall outside the window are counted.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bad_cnt_q <= '0;
        end else if (req_hit && !in_window) begin
            bad_cnt_q <= sat_inc(bad_cnt_q);
        end
    end

    assign rrsm_bad_req_cnt = bad_cnt_q;
`else
    logic unused_oldest;

    assign in_window        = 1'b1;
    assign empty_new        = (unpacker_rdptr_eseq_num == retry_wrt_ptr);
    assign unused_oldest    = ^llrb_oldest_ptr;
    assign rrsm_bad_req_cnt = '0;
`endif

    assign accept = req_hit & in_window;

    // A new request preempts whatever is pending, including an ack or replay step.
    always_comb begin
        state_d  = state_q;
        eseq_d   = eseq_q;
        num_d    = num_q;
        end_d    = end_q;
        empty_d  = empty_q;
        rd_ptr_d = rd_ptr_q;
        if (accept) begin
            state_d = ACK_PEND;
            eseq_d  = unpacker_rdptr_eseq_num;
            num_d   = unpacker_retryreq_num;
            end_d   = retry_wrt_ptr;
            empty_d = empty_new;
        end else begin
            case (state_q)
                ACK_PEND: begin
                    if (controller_ack_sent_flag) begin
                        if (empty_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = REPLAY;
                            rd_ptr_d = eseq_q;
                        end
                    end
                end
                REPLAY: begin
                    if (controller_rd_en) begin
                        rd_ptr_d = rd_ptr_q + PTR_ONE;
                        if (last_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
        ack_d    = (state_d == ACK_PEND);
        active_d = (state_d == REPLAY);
        last_d   = active_d && ((rd_ptr_d + PTR_ONE) == end_d);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            eseq_q   <= '0;
            num_q    <= '0;
            end_q    <= '0;
            empty_q  <= 1'b0;
            rd_ptr_q <= '0;
            ack_q    <= 1'b0;
            active_q <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            eseq_q   <= eseq_d;
            num_q    <= num_d;
            end_q    <= end_d;
            empty_q  <= empty_d;
            rd_ptr_q <= rd_ptr_d;
            ack_q    <= ack_d;
            active_q <= active_d;
            last_q   <= last_d;
        end
    end

    assign retry_send_ack_seq = ack_q;
    assign rrsm_ack_eseq      = eseq_q;
    assign rrsm_ack_num_retry = num_q;
    assign rrsm_ack_empty_bit = empty_q;
    assign rrsm_replay_active = active_q;
    assign rrsm_replay_rd_ptr = rd_ptr_q;
    assign rrsm_replay_last   = last_q;
    assign rrsm_state         = state_q;

endmodule
